flag_reg_unit: RTL and testbench



---
 rtl/flag_reg_unit_pkg.sv | 37 +++
 rtl/flag_reg_unit_if.sv | 36 +++
 rtl/flag_reg_unit_cond_eval.sv | 24 ++
 rtl/flag_reg_unit.sv | 85 ++++++++
 tb/tb_flag_reg_unit.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/flag_reg_unit_pkg.sv
// Shared CPU flag definitions: flag-source select, condition codes, flag bit positions.
package flag_reg_unit_pkg;

    typedef enum logic [2:0] {
        ALU8  = 3'd0,
        ROT   = 3'd1,
        ADD16 = 3'd2,
        MISC  = 3'd3,
        DAA   = 3'd4,
        CPL   = 3'd5,
        RSV6  = 3'd6,
        RSV7  = 3'd7
    } f_src_t;

    typedef enum logic [1:0] {
        COND_NZ = 2'd0,
        COND_Z  = 2'd1,
        COND_NC = 2'd2,
        COND_C  = 2'd3
    } cond_t;

    // Bit positions within the ZNHC nibble (F[7:4] in the full register).
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_H = 1;
    localparam int FLAG_C = 0;

    typedef struct packed {
        logic [3:0] val;
        logic [3:0] mask;
    } f_stage_t;

    function automatic logic [3:0] merge_flags(input logic [3:0] cur, input f_stage_t e);
        return (e.mask & e.val) | (~e.mask & cur);
    endfunction

endpackage

// File: rtl/flag_reg_unit_if.sv
// Controller-side bundle for the flag register stage: decoder inputs, candidate nibbles, F view.
interface flag_reg_unit_if;
    import flag_reg_unit_pkg::*;

    logic       capture;
    logic       commit;
    logic [2:0] next_f_src;
    logic [3:0] f_write;
    logic [3:0] alu_f;
    logic [3:0] rot_f;
    logic [3:0] add16_f;
    logic [3:0] misc_f;
    logic [3:0] daa_f;
    logic [3:0] cpl_f;
    logic       f_load;
    logic [7:0] f_load_data;
    logic [1:0] cond;
    logic       cond_true;
    logic [7:0] f;
    logic       pending;

    modport master (
        output capture, commit, next_f_src, f_write,
        output alu_f, rot_f, add16_f, misc_f, daa_f, cpl_f,
        output f_load, f_load_data, cond,
        input  cond_true, f, pending
    );

    modport slave (
        input  capture, commit, next_f_src, f_write,
        input  alu_f, rot_f, add16_f, misc_f, daa_f, cpl_f,
        input  f_load, f_load_data, cond,
        output cond_true, f, pending
    );

endinterface

// File: rtl/flag_reg_unit_cond_eval.sv
// Combinational branch-condition evaluator (NZ/Z/NC/C) on a ZNHC flag nibble.
module flag_cond_eval
    import flag_reg_unit_pkg::*;
(
    input  logic [3:0] znhc,
    input  cond_t      cond,
    output logic       cond_true
);

    logic unused_nh;
    assign unused_nh = ^{znhc[FLAG_N], znhc[FLAG_H]};

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_NZ: cond_true = ~znhc[FLAG_Z];
            COND_Z:  cond_true =  znhc[FLAG_Z];
            COND_NC: cond_true = ~znhc[FLAG_C];
            COND_C:  cond_true =  znhc[FLAG_C];
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_reg_unit.sv
// Flag register stage: one-entry staging of masked flag updates, commit merge into F, direct loads.
// Build option FLAG_FWD_EN: cond_true evaluates the next-F value instead of registered F.
module flag_reg_unit
    import flag_reg_unit_pkg::*;
#(
    parameter logic [7:0] RESET_F = 8'h00
) (
    input  logic           clk,
    input  logic           reset,
    flag_reg_unit_if.slave bus
);

    f_stage_t   incoming;
    f_stage_t   stage_q, stage_d;
    logic [3:0] f_hi_q, f_hi_d;
    logic       pending_q, pending_d;
    logic [3:0] cond_view;
    logic       unused_low_bits;

    // Only ZNHC are architectural; the low nibble of loads and RESET_F never reaches F.
    assign unused_low_bits = ^{bus.f_load_data[3:0], RESET_F[3:0]};

    always_comb begin
        incoming.val  = 4'b0000;
        incoming.mask = bus.f_write;
        case (f_src_t'(bus.next_f_src))
            ALU8:    incoming.val = bus.alu_f;
            ROT:     incoming.val = bus.rot_f;
            ADD16:   incoming.val = bus.add16_f;
            MISC:    incoming.val = bus.misc_f;
            DAA:     incoming.val = bus.daa_f;
            CPL:     incoming.val = bus.cpl_f;
            default: incoming.mask = 4'b0000;
        endcase
    end

    always_comb begin
        f_hi_d    = f_hi_q;
        pending_d = pending_q;
        stage_d   = stage_q;
        if (bus.f_load) begin
            f_hi_d    = bus.f_load_data[7:4];
            pending_d = 1'b0;
            stage_d   = '0;
        end else if (bus.capture && bus.commit) begin
            // Same-cycle capture and commit bypasses staging straight into F.
            f_hi_d    = merge_flags(f_hi_q, incoming);
            pending_d = 1'b0;
        end else if (bus.capture) begin
            stage_d   = incoming;
            pending_d = 1'b1;
        end else if (bus.commit && pending_q) begin
            f_hi_d    = merge_flags(f_hi_q, stage_q);
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_hi_q    <= RESET_F[7:4];
            pending_q <= 1'b0;
            stage_q   <= '0;
        end else begin
            f_hi_q    <= f_hi_d;
            pending_q <= pending_d;
            stage_q   <= stage_d;
        end
    end

`ifdef FLAG_FWD_EN
    assign cond_view = reset ? RESET_F[7:4] : f_hi_d;
`else
    assign cond_view = f_hi_q;
`endif

    flag_cond_eval u_cond_eval (
        .znhc      (cond_view),
        .cond      (cond_t'(bus.cond)),
        .cond_true (bus.cond_true)
    );

    assign bus.f       = {f_hi_q, 4'b0000};
    assign bus.pending = pending_q;

endmodule

// File: tb/tb_flag_reg_unit.sv
// Scoreboard bench for flag_reg_unit: directed test-plan steps plus random traffic.
module tb_flag_reg_unit;

    logic clk;
    logic reset;

    flag_reg_unit_if bus ();

    flag_reg_unit #(.RESET_F(8'h00)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] f;
        logic       pend;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] m_f;
    logic       m_pend;
    logic [3:0] m_val;
    logic [3:0] m_mask;
    logic       ct_in_cycle;
    logic [3:0] cand [6];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic cond_model(input logic [3:0] v, input logic [1:0] c);
        case (c)
            2'd0:    return ~v[3];
            2'd1:    return  v[3];
            2'd2:    return ~v[0];
            default: return  v[0];
        endcase
    endfunction

    task automatic step(input bit rst, input bit cap, input bit com, input logic [2:0] src,
                        input logic [3:0] mask, input logic [3:0] nib, input bit ld,
                        input logic [7:0] ldat, input logic [1:0] cnd);
        logic [3:0] in_mask;
        logic [3:0] nf;
        logic       np;
        exp_t       e;
        exp_t       got;
        @(negedge clk);
        for (int i = 0; i < 6; i++) cand[i] = 4'($urandom);
        if (src < 3'd6) cand[src] = nib;
        reset           = rst;
        bus.capture     = cap;
        bus.commit      = com;
        bus.next_f_src  = src;
        bus.f_write     = mask;
        bus.alu_f       = cand[0];
        bus.rot_f       = cand[1];
        bus.add16_f     = cand[2];
        bus.misc_f      = cand[3];
        bus.daa_f       = cand[4];
        bus.cpl_f       = cand[5];
        bus.f_load      = ld;
        bus.f_load_data = ldat;
        bus.cond        = cnd;

        in_mask = (src > 3'd5) ? 4'b0000 : mask;
        nf = m_f;
        np = m_pend;
        if (rst) begin
            nf = 4'h0; np = 1'b0; m_val = 4'h0; m_mask = 4'h0;
        end else if (ld) begin
            nf = ldat[7:4]; np = 1'b0;
        end else if (cap && com) begin
            nf = (in_mask & nib) | (~in_mask & m_f); np = 1'b0;
        end else if (cap) begin
            m_val = nib; m_mask = in_mask; np = 1'b1;
        end else if (com && m_pend) begin
            nf = (m_mask & m_val) | (~m_mask & m_f); np = 1'b0;
        end

        #1;
        ct_in_cycle = bus.cond_true;
`ifdef FLAG_FWD_EN
        check_eq("cond_true", bus.cond_true, cond_model(nf, cnd));
`else
        check_eq("cond_true", bus.cond_true, cond_model(m_f, cnd));
`endif
        e.f = {nf, 4'b0000};
        e.pend = np;
        exp_q.push_back(e);
        m_f = nf;
        m_pend = np;

        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq("queue_empty", 1, 0);
        end else begin
            got = exp_q.pop_front();
            check_eq("f", bus.f, got.f);
            check_eq("pending", bus.pending, got.pend);
        end
    endtask

    task automatic idle(input logic [1:0] cnd);
        step(0, 0, 0, 3'd0, 4'h0, 4'h0, 0, 8'h00, cnd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_f = 4'h0; m_pend = 1'b0; m_val = 4'h0; m_mask = 4'h0;
        reset = 1'b1;
        bus.capture = 0; bus.commit = 0; bus.next_f_src = 0; bus.f_write = 0;
        bus.alu_f = 0; bus.rot_f = 0; bus.add16_f = 0; bus.misc_f = 0;
        bus.daa_f = 0; bus.cpl_f = 0; bus.f_load = 0; bus.f_load_data = 0; bus.cond = 0;

        // Reset state and condition view
        step(1, 0, 0, 3'd0, 4'h0, 4'h0, 0, 8'h00, 2'd1);
        check_eq("rst_f", bus.f, 8'h00);
        check_eq("rst_pend", bus.pending, 1'b0);
        idle(2'd1);
        check_eq("rst_cond_z", bus.cond_true, 1'b0);
        idle(2'd0);
        check_eq("rst_cond_nz", bus.cond_true, 1'b1);

        // Capture ALU then commit
        step(0, 1, 0, 3'd0, 4'hF, 4'hA, 0, 8'h00, 2'd0);
        check_eq("cap_pend", bus.pending, 1'b1);
        step(0, 0, 1, 3'd0, 4'h0, 4'h0, 0, 8'h00, 2'd0);
        check_eq("commit_f", bus.f, 8'hA0);
        check_eq("commit_pend", bus.pending, 1'b0);

        // Combined capture+commit, SCF/CCF pattern preserves Z
        step(0, 0, 0, 3'd0, 4'h0, 4'h0, 1, 8'hF5, 2'd0);
        check_eq("load_f0", bus.f, 8'hF0);
        step(0, 1, 1, 3'd3, 4'h7, 4'h1, 0, 8'h00, 2'd1);
        check_eq("bypass_f", bus.f, 8'h90);
        check_eq("bypass_pend", bus.pending, 1'b0);

        // Last capture wins
        step(0, 0, 0, 3'd0, 4'h0, 4'h0, 1, 8'h00, 2'd0);
        step(0, 1, 0, 3'd0, 4'hF, 4'hF, 0, 8'h00, 2'd0);
        step(0, 1, 0, 3'd1, 4'h1, 4'h0, 0, 8'h00, 2'd0);
        step(0, 0, 1, 3'd0, 4'h0, 4'h0, 0, 8'h00, 2'd0);
        check_eq("last_wins_f", bus.f, 8'h00);

        // f_load overrides commit of a pending entry
        step(0, 1, 0, 3'd2, 4'hF, 4'h5, 0, 8'h00, 2'd0);
        step(0, 0, 1, 3'd0, 4'h0, 4'h0, 1, 8'hFF, 2'd0);
        check_eq("load_over_f", bus.f, 8'hF0);
        check_eq("load_over_pend", bus.pending, 1'b0);
        step(0, 0, 1, 3'd0, 4'h0, 4'h0, 0, 8'h00, 2'd0);
        check_eq("commit_nopend_f", bus.f, 8'hF0);

        // Reserved source commits as a no-op
        step(0, 1, 0, 3'd6, 4'hF, 4'h0, 0, 8'h00, 2'd0);
        step(0, 0, 1, 3'd0, 4'h0, 4'h0, 0, 8'h00, 2'd0);
        check_eq("rsv_f", bus.f, 8'hF0);

        // Forwarding: set C from F=00 and test C in the commit cycle
        step(0, 0, 0, 3'd0, 4'h0, 4'h0, 1, 8'h00, 2'd3);
        step(0, 1, 0, 3'd0, 4'h1, 4'h1, 0, 8'h00, 2'd3);
        step(0, 0, 1, 3'd0, 4'h0, 4'h0, 0, 8'h00, 2'd3);
`ifdef FLAG_FWD_EN
        check_eq("fwd_ct_commit", ct_in_cycle, 1'b1);
`else
        check_eq("fwd_ct_commit", ct_in_cycle, 1'b0);
`endif
        idle(2'd3);
        check_eq("ct_after", ct_in_cycle, 1'b1);

        // Reset overrides capture
        step(1, 1, 0, 3'd0, 4'hF, 4'hF, 0, 8'h00, 2'd0);
        check_eq("rst_over_pend", bus.pending, 1'b0);

        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 39) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                 3'($urandom), 4'($urandom), 4'($urandom), ($urandom_range(0, 7) == 0),
                 8'($urandom), 2'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
